// File: rtl/des_pkg.sv
// DES substitution-layer constants: S-box tables, P permutation
// and the P permutation helper shared by the layer RTL.
package des_pkg;

    localparam int S_IN_W  = 48;
    localparam int S_OUT_W = 32;

    // Each row packs 16 nibbles; column 0 sits in the top nibble.
    typedef logic [0:15][3:0] sbox_row_t;

    localparam sbox_row_t SBOX [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
          64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
          64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
          64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
          64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
          64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
          64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
          64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
          64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // Source bit positions, numbered 1 = MSB.
    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [S_OUT_W-1:0] des_p_perm(
        input logic [S_OUT_W-1:0] s
    );
        logic [S_OUT_W-1:0] p;
        p = '0;
        for (int i = 0; i < S_OUT_W; i++) begin
            p[5'(S_OUT_W - 1 - i)] = s[5'(S_OUT_W - P_TAB[i])];
        end
        return p;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One DES S-box: 6-bit chunk in, 4-bit nibble out, pure lookup.
module des_sbox_lut
    import des_pkg::*;
#(
    parameter int SBOX_IDX = 1
) (
    input  logic [5:0] chunk,
    output logic [3:0] nib
);

    if (SBOX_IDX < 1 || SBOX_IDX > 8) begin : g_bad_idx
        $error("des_sbox_lut: SBOX_IDX must be 1..8");
    end

    localparam int TAB = SBOX_IDX - 1;

    logic [1:0] row;
    logic [3:0] col;

    assign row = {chunk[5], chunk[0]};
    assign col = chunk[4:1];
    assign nib = SBOX[TAB][row][col];

endmodule

// File: rtl/des_sbox_layer.sv
// DES S-box layer with optional P permutation, one or two
// register stages behind a valid/ready handshake with a tag.
module des_sbox_layer
    import des_pkg::*;
#(
    parameter int PIPE_STAGES = 1,
    parameter int APPLY_P     = 1,
    parameter int TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [S_IN_W-1:0]  in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [S_OUT_W-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag
);

    if (PIPE_STAGES < 1 || PIPE_STAGES > 2) begin : g_bad_pipe
        $error("des_sbox_layer: PIPE_STAGES must be 1 or 2");
    end
    if (APPLY_P < 0 || APPLY_P > 1) begin : g_bad_p
        $error("des_sbox_layer: APPLY_P must be 0 or 1");
    end
    if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
        $error("des_sbox_layer: TAG_W must be 1..16");
    end

    function automatic logic [S_OUT_W-1:0] finish_word(
        input logic [S_OUT_W-1:0] x
    );
        return (APPLY_P != 0) ? des_p_perm(x) : x;
    endfunction

    logic [S_OUT_W-1:0] s_raw;

    for (genvar g = 0; g < 8; g++) begin : g_lut
        des_sbox_lut #(
            .SBOX_IDX(g + 1)
        ) u_lut (
            .chunk(in_data[S_IN_W-1-6*g -: 6]),
            .nib  (s_raw[S_OUT_W-1-4*g -: 4])
        );
    end

    logic               s0_vld;
    logic [S_OUT_W-1:0] s0_dat;
    logic [TAG_W-1:0]   s0_tag;
    logic [S_OUT_W-1:0] s0_in;
    logic               s0_down;
    logic               s0_ld;

    logic               last_vld;
    logic [S_OUT_W-1:0] last_dat;
    logic [TAG_W-1:0]   last_tag;

    assign s0_ld    = !s0_vld || s0_down;
    assign in_ready = s0_ld && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld <= 1'b0;
            s0_dat <= '0;
            s0_tag <= '0;
        end else if (s0_ld) begin
            s0_vld <= in_valid;
            if (in_valid) begin
                s0_dat <= s0_in;
                s0_tag <= in_tag;
            end
        end
    end

    if (PIPE_STAGES == 1) begin : g_one
        assign s0_in    = finish_word(s_raw);
        assign s0_down  = out_ready;
        assign last_vld = s0_vld;
        assign last_dat = s0_dat;
        assign last_tag = s0_tag;
    end else begin : g_two
        logic               s1_vld;
        logic [S_OUT_W-1:0] s1_dat;
        logic [TAG_W-1:0]   s1_tag;
        logic               s1_ld;

        // P is applied on the second stage, after the lookup register.
        assign s0_in   = s_raw;
        assign s1_ld   = !s1_vld || out_ready;
        assign s0_down = s1_ld;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_vld <= 1'b0;
                s1_dat <= '0;
                s1_tag <= '0;
            end else if (s1_ld) begin
                s1_vld <= s0_vld;
                if (s0_vld) begin
                    s1_dat <= finish_word(s0_dat);
                    s1_tag <= s0_tag;
                end
            end
        end

        assign last_vld = s1_vld;
        assign last_dat = s1_dat;
        assign last_tag = s1_tag;
    end

    assign out_valid = last_vld && !rst;
    assign out_data  = last_dat;
    assign out_tag   = last_tag;

endmodule

// File: tb/tb_des_sbox_layer.sv
// Bench for des_sbox_layer: directed FIPS/corner/handshake cases
// plus random traffic against a table-driven reference model.
module tb_des_sbox_layer;

    localparam logic [63:0] ST [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
        64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
        64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
        64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
        64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
        64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
        64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
        64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
        64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    localparam int PT [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [47:0] in_data;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        ir [3];
    logic        ov [3];
    logic [31:0] od [3];
    logic [3:0]  ot [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    des_sbox_layer #(.PIPE_STAGES(1), .APPLY_P(1), .TAG_W(4)) u_p1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_tag(ot[0])
    );

    des_sbox_layer #(.PIPE_STAGES(1), .APPLY_P(0), .TAG_W(4)) u_r1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_tag(ot[1])
    );

    des_sbox_layer #(.PIPE_STAGES(2), .APPLY_P(1), .TAG_W(4)) u_p2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_tag(ot[2])
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic int sbox_ref(input int s, input int v);
        int row;
        int col;
        row = ((v >> 5) & 1) * 2 + (v & 1);
        col = (v >> 1) & 15;
        return int'((ST[s * 4 + row] >> (4 * (15 - col))) & 64'hF);
    endfunction

    function automatic logic [31:0] ref_word(input logic [47:0] x,
                                             input int ap);
        longint unsigned s;
        longint unsigned p;
        longint unsigned xv;
        s  = 0;
        p  = 0;
        xv = 64'(x);
        for (int j = 0; j < 8; j++) begin
            s = (s << 4) | 64'(sbox_ref(j, int'((xv >> (42 - 6 * j)) & 63)));
        end
        if (ap == 0) return 32'(s);
        for (int i = 0; i < 32; i++) begin
            p = p | (((s >> (32 - PT[i])) & 1) << (31 - i));
        end
        return 32'(p);
    endfunction

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_sb
        localparam int AP = (k == 1) ? 0 : 1;
        logic [35:0] q [$];
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                chk($sformatf("rst_in_ready%0d", k), 64'(ir[k]), 64'd0);
                chk($sformatf("rst_out_valid%0d", k), 64'(ov[k]), 64'd0);
            end else begin
                if (ov[k]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("spurious%0d", k), 64'(ov[k]), 64'd0);
                    end else begin
                        chk($sformatf("sb_word%0d", k),
                            64'({ot[k], od[k]}), 64'(q[0]));
                        if (out_ready) void'(q.pop_front());
                    end
                end
                if (in_valid && ir[k]) begin
                    q.push_back({in_tag, ref_word(in_data, AP)});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string nm);
        chk({nm, "_q0"}, 64'(g_sb[0].q.size()), 64'd0);
        chk({nm, "_q1"}, 64'(g_sb[1].q.size()), 64'd0);
        chk({nm, "_q2"}, 64'(g_sb[2].q.size()), 64'd0);
        for (int k = 0; k < 3; k++) chk({nm, "_ov"}, 64'(ov[k]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_tag = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_in_ready", 64'(ir[k]), 64'd1);
            chk("post_rst_out_valid", 64'(ov[k]), 64'd0);
            chk("post_rst_out_data", 64'(od[k]), 64'd0);
            chk("post_rst_out_tag", 64'(ot[k]), 64'd0);
        end
        step();

        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 48'h6117BA866527;
        in_tag = 4'd3;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fips_p1_valid", 64'(ov[0]), 64'd1);
        chk("fips_p1_data", 64'(od[0]), 64'h234AA9BB);
        chk("fips_p1_tag", 64'(ot[0]), 64'd3);
        chk("fips_raw_data", 64'(od[1]), 64'h5C82B597);
        chk("fips_p2_early", 64'(ov[2]), 64'd0);
        step();
        @(negedge clk);
        chk("fips_p2_valid", 64'(ov[2]), 64'd1);
        chk("fips_p2_data", 64'(od[2]), 64'h234AA9BB);
        chk("fips_p2_tag", 64'(ot[2]), 64'd3);
        chk("fips_p1_gone", 64'(ov[0]), 64'd0);
        step();

        in_valid = 1'b1;
        in_data = 48'h0;
        in_tag = 4'd7;
        step();
        in_data = 48'hFFFFFFFFFFFF;
        in_tag = 4'd8;
        @(negedge clk);
        chk("zero_raw", 64'(od[1]), 64'hEFA72C4D);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ones_raw", 64'(od[1]), 64'hD9CE3DCB);
        chk("ones_s6", 64'(od[1][11:8]), 64'd13);
        step();
        step();

        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                in_valid = 1'b1;
                in_data = rnd48();
                in_tag = 4'(c);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("stream_p2_valid", 64'(ov[2]), 64'(c >= 2 && c <= 17));
            if (c >= 2 && c <= 17) chk("stream_p2_tag", 64'(ot[2]), 64'(c - 2));
            chk("stream_p1_valid", 64'(ov[0]), 64'(c >= 1 && c <= 16));
            if (c >= 1 && c <= 16) chk("stream_p1_tag", 64'(ot[0]), 64'(c - 1));
            step();
        end

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = rnd48();
        in_tag = 4'd1;
        step();
        in_data = rnd48();
        in_tag = 4'd2;
        step();
        in_data = rnd48();
        in_tag = 4'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("bp_in_ready", 64'(ir[k]), 64'd0);
                chk("bp_out_valid", 64'(ov[k]), 64'd1);
                chk("bp_out_tag", 64'(ot[k]), 64'd1);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready_p2", 64'(ir[2]), 64'd1);
        chk("bp_release_ready_p1", 64'(ir[0]), 64'd1);
        chk("bp_release_tag_p2", 64'(ot[2]), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_tag_p2", 64'(ot[2]), 64'd2);
        chk("bp_next_tag_p1", 64'(ot[0]), 64'd3);
        step();
        @(negedge clk);
        chk("bp_last_tag_p2", 64'(ot[2]), 64'd3);
        chk("bp_last_valid_p2", 64'(ov[2]), 64'd1);
        step();
        step();
        chk_empty("bp_drain");

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = rnd48();
        in_tag = 4'd5;
        step();
        in_data = rnd48();
        in_tag = 4'd6;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_p2_valid", 64'(ov[2]), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("midrst_out_valid", 64'(ov[k]), 64'd0);
            chk("midrst_out_data", 64'(od[k]), 64'd0);
            chk("midrst_out_tag", 64'(ot[k]), 64'd0);
            chk("midrst_in_ready", 64'(ir[k]), 64'd1);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk("midrst_quiet", 64'(ov[k]), 64'd0);
        end
        step();

        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 99) < 70);
            in_data = rnd48();
            in_tag = 4'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk_empty("rand_drain");

        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < 64; v++) begin
                in_valid = 1'b1;
                in_data = 48'(v) << (42 - 6 * s);
                in_tag = 4'(v);
                step();
                in_valid = 1'b0;
                @(negedge clk);
                chk($sformatf("exh_s%0d_%0d", s + 1, v),
                    64'((od[1] >> (28 - 4 * s)) & 32'hF),
                    64'(sbox_ref(s, v)));
                step();
            end
        end
        step();
        chk_empty("exh_drain");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
